// File: rtl/bidir_link_pkg.sv
// Shared definitions for the half-duplex link responder: state codes, parity, counter sizing.
// Optional parity states exist only when BIDIR_PARITY_EN is defined.
package bidir_link_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_RX_START = 4'd1;
  localparam state_t ST_RX_BITS  = 4'd2;
  localparam state_t ST_RX_STOP  = 4'd3;
  localparam state_t ST_TURN     = 4'd4;
  localparam state_t ST_TX_START = 4'd5;
  localparam state_t ST_TX_BITS  = 4'd6;
  localparam state_t ST_TX_STOP  = 4'd7;
`ifdef BIDIR_PARITY_EN
  localparam state_t ST_RX_PAR   = 4'd8;
  localparam state_t ST_TX_PAR   = 4'd9;
`endif

  // The turnaround load is BIT_CYCLES/2 + TURN_CYCLES, which never exceeds twice the larger one.
  function automatic int cnt_width(input int bit_cycles, input int turn_cycles);
    int m;
    m = (bit_cycles > turn_cycles) ? bit_cycles : turn_cycles;
    return $clog2(2 * m + 1);
  endfunction

  function automatic logic even_parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/bidir_bit_timer.sv
// Loadable down-counter; tick is high during the last cycle of a loaded interval,
// so an action taken on tick lands exactly 'value' cycles after the load edge.
module bidir_bit_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] value,
  output logic          tick
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == CW'(1));

endmodule

// File: rtl/bidir_link_responder.sv
// Responder end of a single-wire half-duplex serial link: receive a frame, turn the line, reply.
// Even parity on both directions when BIDIR_PARITY_EN is defined.
module bidir_link_responder
  import bidir_link_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int BIT_CYCLES  = 16,
  parameter int TURN_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire              data,
  output logic             dir,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_done,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = cnt_width(BIT_CYCLES, TURN_CYCLES);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] BIT_LEN  = CW'(BIT_CYCLES);
  localparam logic [CW-1:0] HALF_LEN = CW'(BIT_CYCLES / 2);
  localparam logic [CW-1:0] TURN_LEN = CW'(BIT_CYCLES / 2 + TURN_CYCLES);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t state, state_nxt;
  logic sync1, data_s;
  logic [1:0] mask;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic [WIDTH-1:0] rx_shift, tx_word;
  logic tx_bit, tx_bit_nxt, dir_nxt;
  logic tmr_load, tick;
  logic [CW-1:0] tmr_val;
  logic rx_ok, err, done, sample, latch, bit_clr, bit_inc;

  bidir_bit_timer #(.CW(CW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (tmr_val),
    .tick  (tick)
  );

  assign data    = dir ? tx_bit : 1'bz;
  assign busy    = (state != ST_IDLE);
  assign bit_nxt = bit_cnt + 1'b1;

  always_comb begin
    state_nxt  = state;
    tmr_load   = 1'b0;
    tmr_val    = BIT_LEN;
    rx_ok      = 1'b0;
    err        = 1'b0;
    done       = 1'b0;
    sample     = 1'b0;
    latch      = 1'b0;
    bit_clr    = 1'b0;
    bit_inc    = 1'b0;
    tx_bit_nxt = tx_bit;
    dir_nxt    = dir;
    case (state)
      ST_IDLE: if (!data_s && mask == 2'd0) begin
        state_nxt = ST_RX_START;
        tmr_load  = 1'b1;
        tmr_val   = HALF_LEN;
      end
      ST_RX_START: if (tick) begin
        // A start bit that has gone high by mid-bit is line noise, not a frame.
        if (!data_s) begin
          state_nxt = ST_RX_BITS;
          tmr_load  = 1'b1;
          bit_clr   = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RX_BITS: if (tick) begin
        sample   = 1'b1;
        tmr_load = 1'b1;
        if (bit_cnt == LAST_BIT) begin
`ifdef BIDIR_PARITY_EN
          state_nxt = ST_RX_PAR;
`else
          state_nxt = ST_RX_STOP;
`endif
        end else begin
          bit_inc = 1'b1;
        end
      end
`ifdef BIDIR_PARITY_EN
      ST_RX_PAR: if (tick) begin
        if (data_s != even_parity(32'(rx_shift))) begin
          err       = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_RX_STOP;
          tmr_load  = 1'b1;
        end
      end
`endif
      ST_RX_STOP: if (tick) begin
        if (!data_s) begin
          err       = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          rx_ok     = 1'b1;
          state_nxt = ST_TURN;
          tmr_load  = 1'b1;
          tmr_val   = TURN_LEN;
        end
      end
      ST_TURN: begin
        // Any low level while released means the initiator is still talking.
        if (!data_s) begin
          err       = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tick) begin
          if (tx_valid) begin
            latch      = 1'b1;
            state_nxt  = ST_TX_START;
            tmr_load   = 1'b1;
            dir_nxt    = 1'b1;
            tx_bit_nxt = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_TX_START: if (tick) begin
        state_nxt  = ST_TX_BITS;
        tmr_load   = 1'b1;
        bit_clr    = 1'b1;
        tx_bit_nxt = tx_word[0];
      end
      ST_TX_BITS: if (tick) begin
        tmr_load = 1'b1;
        if (bit_cnt == LAST_BIT) begin
`ifdef BIDIR_PARITY_EN
          state_nxt  = ST_TX_PAR;
          tx_bit_nxt = even_parity(32'(tx_word));
`else
          state_nxt  = ST_TX_STOP;
          tx_bit_nxt = 1'b1;
`endif
        end else begin
          bit_inc    = 1'b1;
          tx_bit_nxt = tx_word[bit_nxt];
        end
      end
`ifdef BIDIR_PARITY_EN
      ST_TX_PAR: if (tick) begin
        state_nxt  = ST_TX_STOP;
        tmr_load   = 1'b1;
        tx_bit_nxt = 1'b1;
      end
`endif
      ST_TX_STOP: if (tick) begin
        state_nxt = ST_IDLE;
        dir_nxt   = 1'b0;
        done      = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sync1     <= 1'b1;
      data_s    <= 1'b1;
      mask      <= 2'd0;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_word   <= '0;
      tx_bit    <= 1'b1;
      dir       <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync1     <= data;
      data_s    <= sync1;
      state     <= state_nxt;
      dir       <= dir_nxt;
      tx_bit    <= tx_bit_nxt;
      rx_valid  <= rx_ok;
      frame_err <= err;
      tx_done   <= done;
      // Keep our own trailing edge out of start detection while the synchronizer drains.
      if (done) mask <= 2'd2;
      else if (mask != 2'd0) mask <= mask - 1'b1;
      if (bit_clr) bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_nxt;
      if (sample) rx_shift[bit_cnt] <= data_s;
      if (rx_ok) rx_data <= rx_shift;
      if (latch) tx_word <= tx_data;
    end
  end

endmodule

// File: doc/bidir_link_responder.md
# bidir_link_responder

Responder end of the single-wire half-duplex link built on the bidirectional data line. Receives a serial frame driven by the initiator, presents the word locally, then turns the line around and drives a response frame before releasing it. It sits between the shared `data` pin and local logic. It owns the line direction (`dir`) and never drives the line while the initiator may be driving it.

## Interface
- `WIDTH`, 8: data bits per frame, 1–32.
- `BIT_CYCLES`, 16: clocks per bit. Even, ≥4.
- `TURN_CYCLES`, 8: clocks of released line between RX stop bit end and TX start bit. ≥2.

- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `data` inout 1: shared line. External pull-up; line reads 1 when released. Driven only when `dir`=1.
- `dir` out 1: 1 = responder driving `data`, 0 = released.
- `rx_data` out WIDTH: last received word. Held until the next valid frame.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `tx_data` in WIDTH: response word.
- `tx_valid` in 1: response available. Sampled at the end of the turnaround.
- `tx_done` out 1: one-cycle pulse when the line is released after the TX stop bit.
- `frame_err` out 1: one-cycle pulse on bad stop bit, parity error, or collision.
- `busy` out 1: high in every state except IDLE.

## Operation
- Frame format, both directions: start bit (0), WIDTH data bits LSB first, [parity], stop bit (1). Each bit lasts BIT_CYCLES.
- `data` passes through a 2-flop synchronizer (`data_s`) before any use.
- States:
  - IDLE: `dir`=0. `data_s`=0 → RX_START.
  - RX_START: count BIT_CYCLES/2. If `data_s` is still 0, → RX_BITS. Otherwise it is a glitch: → IDLE with no error.
  - RX_BITS: sample `data_s` every BIT_CYCLES (mid-bit) into a shift register, WIDTH samples. Then → RX_STOP.
  - RX_STOP: sample after BIT_CYCLES.
    - Sample 0 → `frame_err`, → IDLE.
    - Sample 1 → `rx_data` updated, `rx_valid` pulse, → TURN.
  - TURN: wait TURN_CYCLES counted from the stop-bit sample point plus BIT_CYCLES/2, i.e. the stop bit end. `data_s`=0 at any point → collision: `frame_err`, → IDLE. At the last cycle:
    - `tx_valid`=1 → latch `tx_data`, → TX_START.
    - `tx_valid`=0 → IDLE, no response.
  - TX_START: `dir`=1, drive 0 for BIT_CYCLES.
  - TX_BITS: drive latched bits LSB first, BIT_CYCLES each.
  - TX_STOP: drive 1 for BIT_CYCLES. Then `dir`=0, `tx_done` pulse, → IDLE.
- `tx_data` changes after the latch do not affect the frame in flight.
- Own transmission is not received: IDLE start detection is masked for 2 cycles after release, covering the synchronizer depth.

## Timing
- Reset values (`rst_n`=0 at a clock edge, any state, including mid-TX):
  - `dir`=0, line released next cycle.
  - `rx_data`=0.
  - `rx_valid`=`tx_done`=`frame_err`=`busy`=0.
  - State IDLE, counters 0.
- Start detect latency: 2 cycles from the line falling to `data_s` falling, 1 more to RX_START.
- `rx_valid` is asserted the cycle after the stop-bit sample.
- First TX start bit drives at the stop-bit sample + BIT_CYCLES/2 + TURN_CYCLES cycles.
- TX frame length: (WIDTH+2) × BIT_CYCLES cycles, or (WIDTH+3) × BIT_CYCLES with parity. The `dir` high span equals this exactly.
- `tx_done` is asserted in the same cycle `dir` falls.
- Pulses never overlap: at most one of `rx_valid`, `frame_err`, `tx_done` per cycle.

## Configuration
- `BIDIR_PARITY_EN` defined: an even-parity bit follows the data bits in both directions.
  - RX: parity is checked at the parity sample. A mismatch gives `frame_err`, → IDLE, and `rx_valid` is not asserted.
  - TX: the responder generates the parity bit.
- `BIDIR_PARITY_EN` undefined: no parity bit, and frame timing is as above without it.

## Structure
- Package `bidir_link_pkg`:
  - state enum: IDLE, RX_START, RX_BITS, RX_STOP, TURN, TX_START, TX_BITS, TX_STOP, plus RX_PAR/TX_PAR under the macro.
  - `even_parity` function.
  - counter width constant derived from the maximum of BIT_CYCLES and TURN_CYCLES.
- One sub-module, `bidir_bit_timer`:
  - loadable down-counter with a `tick` output.
  - shared by all states for bit, half-bit and turnaround timing.
- Tristate assignment lives in the top level only.

## Test plan
Bench uses `pullup` on `data`, BIT_CYCLES=16, TURN_CYCLES=8.

- Initiator sends 0xA5, `tx_valid`=1, `tx_data`=0x3C → `rx_valid` pulse with `rx_data`=0xA5; after the turnaround the responder drives 0,0,0,1,1,1,1,0,0,1, then `tx_done`, `dir`=0.
- Same frame with `tx_valid`=0 → `rx_valid` pulse, no drive, `dir` stays 0, IDLE after TURN.
- 4-cycle low glitch in IDLE → no `rx_valid` or `frame_err`, `busy` back to 0.
- Stop bit forced 0 → `frame_err` pulse, `rx_data` unchanged, no response.
- Initiator pulls the line low during TURN → `frame_err`, `dir` never asserts.
- `rst_n`=0 mid-TX_BITS → `dir`=0 next cycle and all outputs 0. A new 0x5A frame after release → normal response.
